bram_bist: RTL and testbench
============================

# bram_bist

Built-in self-test controller for the simple dual-port synchronous-read block RAM (registered read port, one write port). Drives the RAM's write and read ports through a four-phase march (write pattern, verify, write complement, verify) and reports pass/fail with the first failing address and data. Sits beside an inferred BRAM in hardware-test and bring-up designs; in normal operation it idles with all RAM-side outputs inactive.

## Interface
- ABITS, 8, RAM address width; N = 2**ABITS words tested
- DBITS, 8, RAM data width
- clk  input  1  sole clock, rising edge
- resetn  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to run the test
- busy  output  1  high while the test runs
- done  output  1  high from test end until the next accepted start
- pass  output  1  valid while done; 1 means no mismatch
- fail_addr  output  ABITS  first mismatching address; 0 if pass
- fail_data  output  DBITS  RD_DATA seen at fail_addr; 0 if pass
- WR_ADDR  output  ABITS  RAM write address
- WR_DATA  output  DBITS  RAM write data
- WR_EN  output  1  RAM write enable
- RD_ADDR  output  ABITS  RAM read address
- RD_DATA  input  DBITS  RAM read data, valid one clk after RD_ADDR is sampled

## Operation
- Pattern P(a, inv): a replicated LSB-first to fill DBITS, truncated at the MSB, then XORed with all-ones if inv. Example: ABITS=4, DBITS=8, a=3 gives 8'h33, or 8'hCC with inv.
- States: IDLE, WR0, RD0, WR1, RD1, DONE.
- IDLE/DONE: start=1 loads addr counter 0, clears done/pass/fail_*, and moves to WR0. start in any other state is ignored.
- WR0/WR1: WR_EN=1, WR_ADDR=counter, WR_DATA=P(counter, 0/1). Runs N cycles. After counter N-1, moves to RD0/RD1.
- RD0/RD1: RD_ADDR=counter for N issue cycles, then one drain cycle. Each issued address is carried with a valid bit into a one-stage compare register. RD_DATA is compared to P(addr, inv) the following cycle.
- Mismatch: latch fail_addr and fail_data, set pass=0, go to DONE immediately. Reads still in flight are discarded.
- RD1 finishes with no mismatch: pass=1, go to DONE.
- RD0 finishes with no mismatch: go to WR1.
- No read and write are ever active in the same cycle, so no read-during-write case occurs.
- WR_EN is 0 in every state except WR0/WR1.
- The address counter is ABITS+1 bits wide to detect the end of a phase. WR_ADDR and RD_ADDR take its low ABITS bits.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, pass=0, fail_addr=0, fail_data=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, RD_ADDR=0. State resets to IDLE.
- start sampled at edge t: busy=1 and the first write (WR_EN=1, WR_ADDR=0) are visible after t+1.
- Fault-free run: 4N+2 cycles in WR0..RD1. done=1 and busy=0 appear on the same edge.
- Mismatch on the read issued at cycle k: done=1 at k+2.
- resetn asserted mid-test: all outputs go to reset values immediately. The RAM contents are left undefined for the next run.
- start asserted on the same edge done would rise: ignored.

## Structure
- Package bram_bist_pkg holds:
  - the state enum
  - the pattern function P(a, inv), parameterised by ABITS/DBITS
- Sub-module bram_bist_check holds the one-stage compare pipeline: expected-data/address/valid registers, mismatch flag, and first-fail capture.
- The top level holds the FSM and address counter.

## Test plan
Each scenario uses ABITS=4, DBITS=8 and a behavioural RAM with a 1-cycle registered read.
- Reset, no start: all outputs 0 for 100 cycles; WR_EN never 1.
- Clean RAM, start pulse: write sequence 8'h00, 8'h11 … 8'hFF, then 8'hFF … 8'h00. done=1 and pass=1 exactly 66 cycles after the first write; fail_addr=0.
- RAM bit 2 stuck-at-0 at address 5: fail_addr=5, fail_data=8'h51, pass=0. done rises 2 cycles after RD_ADDR=5 in RD0; no WR1 writes occur.
- RAM bit 0 stuck-at-1 at address 9: passes RD0; fails in RD1 with fail_addr=9, fail_data=8'h67, pass=0.
- start pulsed during WR0 and RD1: ignored, total cycle count unchanged. start in DONE clears done/pass and reruns.
- resetn dropped mid-RD0, then released and start pulsed: outputs zero asynchronously; full 66-cycle pass run completes.

Source files
------------

// File: rtl/bram_bist_pkg.sv
// Shared state encoding and data-pattern helper for the BRAM march self-test.
package bram_bist_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_WR0  = 3'd1;
  localparam state_t S_RD0  = 3'd2;
  localparam state_t S_WR1  = 3'd3;
  localparam state_t S_RD1  = 3'd4;
  localparam state_t S_DONE = 3'd5;

  // Address bits repeated LSB-first across the data word; callers truncate to their width.
  function automatic logic [63:0] pattern(input logic [31:0] a, input int abits,
                                          input int dbits, input logic inv);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < dbits) p[i] = a[i % abits] ^ inv;
    end
    return p;
  endfunction

endpackage

// File: rtl/bram_bist_check.sv
// One-stage read compare: holds the address/expected word of the read in flight and captures the first failure.
module bram_bist_check
  import bram_bist_pkg::*;
#(
  parameter int ABITS = 8,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr_i,
  input  logic             issue_vld_i,
  input  logic             issue_inv_i,
  input  logic [ABITS-1:0] issue_addr_i,
  input  logic [DBITS-1:0] rd_data_i,
  output logic             mismatch_o,
  output logic [ABITS-1:0] fail_addr_o,
  output logic [DBITS-1:0] fail_data_o
);

  logic             vld_p1_q;
  logic [ABITS-1:0] addr_p1_q;
  logic signed [DBITS-1:0] exp_p1_q;
  logic [ABITS-1:0] fail_addr_q, fail_addr_d;
  logic [DBITS-1:0] fail_data_q, fail_data_d;

  assign mismatch_o = vld_p1_q && (rd_data_i != exp_p1_q);

  always_comb begin
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    if (clr_i) begin
      fail_addr_d = '0;
      fail_data_d = '0;
    end else if (mismatch_o) begin
      fail_addr_d = addr_p1_q;
      fail_data_d = rd_data_i;
    end
  end

  // Stage p1: read issued last cycle, its data arrives now; a failure flushes anything behind it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1_q    <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      vld_p1_q    <= issue_vld_i && !mismatch_o;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_p1_q <= issue_addr_i;
    exp_p1_q  <= DBITS'(pattern(32'(issue_addr_i), ABITS, DBITS, issue_inv_i));
  end

  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;

endmodule

// File: rtl/bram_bist.sv
// March BIST controller (write P, verify, write ~P, verify) for a registered-read dual-port BRAM.
module bram_bist
  import bram_bist_pkg::*;
#(
  parameter int ABITS = 8,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ABITS-1:0] fail_addr,
  output logic [DBITS-1:0] fail_data,
  output logic [ABITS-1:0] WR_ADDR,
  output logic [DBITS-1:0] WR_DATA,
  output logic             WR_EN,
  output logic [ABITS-1:0] RD_ADDR,
  input  logic [DBITS-1:0] RD_DATA
);

  localparam logic [ABITS:0] LAST_WR = {1'b0, {ABITS{1'b1}}};
  localparam logic [ABITS:0] CNT_ONE = (ABITS+1)'(1);

  state_t           state_q, state_d;
  logic [ABITS:0]   cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             wr_en_q, wr_en_d;
  logic [ABITS-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [DBITS-1:0] wr_data_q, wr_data_d;
  logic             clr, mismatch, in_rd, wr_nxt, rd_nxt;

  assign in_rd = (state_q == S_RD0) || (state_q == S_RD1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    clr     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WR0;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          clr     = 1'b1;
        end
      end
      S_WR0, S_WR1: begin
        if (cnt_q == LAST_WR) begin
          state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RD0, S_RD1: begin
        if (mismatch) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else if (cnt_q[ABITS]) begin
          // Drain cycle: the last read has just been compared
          if (state_q == S_RD0) begin
            state_d = S_WR1;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_nxt    = (state_d == S_WR0) || (state_d == S_WR1);
    rd_nxt    = ((state_d == S_RD0) || (state_d == S_RD1)) && !cnt_d[ABITS];
    busy_d    = wr_nxt || (state_d == S_RD0) || (state_d == S_RD1);
    wr_en_d   = wr_nxt;
    wr_addr_d = wr_nxt ? cnt_d[ABITS-1:0] : '0;
    wr_data_d = wr_nxt ? DBITS'(pattern(32'(cnt_d[ABITS-1:0]), ABITS, DBITS, state_d == S_WR1))
                       : '0;
    rd_addr_d = rd_nxt ? cnt_d[ABITS-1:0] : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  bram_bist_check #(.ABITS(ABITS), .DBITS(DBITS)) u_check (
    .clk         (clk),
    .resetn      (resetn),
    .clr_i       (clr),
    .issue_vld_i (in_rd && !cnt_q[ABITS]),
    .issue_inv_i (state_q == S_RD1),
    .issue_addr_i(rd_addr_q),
    .rd_data_i   (RD_DATA),
    .mismatch_o  (mismatch),
    .fail_addr_o (fail_addr),
    .fail_data_o (fail_data)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign WR_EN   = wr_en_q;
  assign WR_ADDR = wr_addr_q;
  assign WR_DATA = wr_data_q;
  assign RD_ADDR = rd_addr_q;

endmodule

// File: tb/tb_bram_bist.sv
// Scoreboard bench for bram_bist against a behavioural registered-read RAM with injectable stuck bits.
module tb_bram_bist;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass, WR_EN;
  logic [3:0] fail_addr, WR_ADDR, RD_ADDR;
  logic [7:0] fail_data, WR_DATA, RD_DATA;

  logic [7:0] mem [16];
  logic [3:0] f_addr = 4'd0;
  logic [7:0] f_sa0 = 8'h00, f_sa1 = 8'h00;

  typedef struct {
    logic       pass;
    logic [3:0] fa;
    logic [7:0] fd;
    int         cyc;
  } res_t;

  res_t        res_q[$];
  logic [11:0] wr_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  bram_bist #(.ABITS(4), .DBITS(8)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA),
    .WR_EN    (WR_EN),
    .RD_ADDR  (RD_ADDR),
    .RD_DATA  (RD_DATA)
  );

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    RD_DATA = 8'h00;
  end

  always @(posedge clk) begin
    if (WR_EN) mem[WR_ADDR] <= WR_DATA;
    if (RD_ADDR == f_addr) RD_DATA <= (mem[RD_ADDR] & ~f_sa0) | f_sa1;
    else                   RD_DATA <= mem[RD_ADDR];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int a, input int inv);
    logic [3:0] a4;
    a4 = 4'(a);
    return {a4, a4} ^ {8{inv[0]}};
  endfunction

  // Push the expected writes and outcome, pulse start, then follow the run to done.
  task automatic run(input logic [3:0] fa, input logic [7:0] sa0, input logic [7:0] sa1,
                     input bit extra_starts);
    res_t       r;
    logic [7:0] p, v;
    int         nwr, done_cyc;
    f_addr = fa; f_sa0 = sa0; f_sa1 = sa1;
    r.pass = 1'b1; r.fa = 4'd0; r.fd = 8'h00; r.cyc = 66; nwr = 32;
    for (int ph = 0; ph < 2 && r.pass; ph++) begin
      for (int a = 0; a < 16 && r.pass; a++) begin
        p = pat(a, ph);
        v = (4'(a) == fa) ? ((p & ~sa0) | sa1) : p;
        if (v != p) begin
          r.pass = 1'b0; r.fa = 4'(a); r.fd = v;
          r.cyc  = (ph == 0) ? 16 + a + 2 : 49 + a + 2;
          nwr    = (ph == 0) ? 16 : 32;
        end
      end
    end
    res_q.push_back(r);
    for (int i = 0; i < nwr; i++) wr_q.push_back({4'(i), pat(i, (i >= 16) ? 1 : 0)});

    @(negedge clk);
    start = 1'b1;
    done_cyc = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      start = extra_starts && (cyc == 3 || cyc == 55 || cyc == 65);
      if (cyc == 0) begin
        check_eq("busy_at_start", 32'(busy), 32'd1);
        check_eq("done_cleared", 32'(done), 32'd0);
        check_eq("pass_cleared", 32'(pass), 32'd0);
        check_eq("faddr_cleared", 32'(fail_addr), 32'd0);
        check_eq("first_write", 32'(WR_EN), 32'd1);
      end
      if (WR_EN) begin
        if (wr_q.size() == 0) check_eq("wr_extra", 32'(WR_ADDR), 32'hFFFF);
        else check_eq("wr_addr_data", 32'({WR_ADDR, WR_DATA}), 32'(wr_q.pop_front()));
      end
      if (done && done_cyc < 0) begin
        done_cyc = cyc;
        r = res_q.pop_front();
        check_eq("pass", 32'(pass), 32'(r.pass));
        check_eq("fail_addr", 32'(fail_addr), 32'(r.fa));
        check_eq("fail_data", 32'(fail_data), 32'(r.fd));
        check_eq("cycles_to_done", 32'(cyc), 32'(r.cyc));
        check_eq("busy_at_done", 32'(busy), 32'd0);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 3) begin
        check_eq("done_hold", 32'(done), 32'd1);
        check_eq("idle_no_write", 32'(WR_EN), 32'd0);
        break;
      end
    end
    start = 1'b0;
    if (done_cyc < 0) check_eq("done_timeout", 32'd0, 32'd1);
    check_eq("writes_left", 32'(wr_q.size()), 32'd0);
    wr_q.delete();
    res_q.delete();
  endtask

  initial begin
    logic        any_out, any_wr;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    any_out = 1'b0; any_wr = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      any_out |= |{busy, done, pass, fail_addr, fail_data, WR_ADDR, WR_DATA, RD_ADDR};
      any_wr  |= WR_EN;
    end
    check_eq("reset_outputs", 32'(any_out), 32'd0);
    check_eq("reset_no_wr_en", 32'(any_wr), 32'd0);

    run(4'd0, 8'h00, 8'h00, 1'b1);
    run(4'd5, 8'h04, 8'h00, 1'b0);
    run(4'd9, 8'h00, 8'h01, 1'b0);
    run(4'd0, 8'h00, 8'h00, 1'b0);

    // Drop reset asynchronously in RD0, then rerun cleanly
    f_sa0 = 8'h00; f_sa1 = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("mid_rd0_busy", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_eq("async_reset_outputs",
             32'({busy, done, pass, WR_EN, fail_addr, fail_data, WR_ADDR, WR_DATA, RD_ADDR}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run(4'd0, 8'h00, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
